// File: rtl/fetch_queue_stage_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// Responses are in order and cannot be back-pressured.
interface fetch_queue_stage_if;
  logic        i_req_valid;
  logic        i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_data
  );

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_rsp_valid, i_rsp_data
  );
endinterface

// File: rtl/fetch_queue_stage.sv
// Fetch stage with a reservation queue decoupling PC generation from in-order imem.
// Optional FETCH_PERF_CNT_EN adds saturating squash/bubble performance counters.
module fetch_queue_stage #(
  parameter logic [31:0] BootVector = 32'h0000_0000,
  parameter int          Depth      = 4,
  parameter logic [31:0] NopInstr   = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                reset,
  fetch_queue_stage_if.master mem,
  input  logic                halted,
  output logic [31:0]         instr_f,
  output logic [31:0]         pc_f,
  output logic [31:0]         pc4_f,
  output logic                valid_f,
  input  logic                stall,
  input  logic                flush,
  input  logic                jump_d,
  input  logic [31:0]         pc_imm_d,
  input  logic [1:0]          pc_sel_e,
  input  logic [31:0]         pc_imm_e,
  input  logic [31:0]         alsu_res_e,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]         perf_squash_cnt,
  output logic [31:0]         perf_bubble_cnt,
`endif
  output logic                misaligned_pc
);
  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;

  logic [31:0]    fetch_pc;
  logic [31:0]    pc_q   [Depth];
  logic [31:0]    data_q [Depth];
  logic [Depth-1:0] filled_q;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [PW-1:0]  fill_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  pending;
  logic [CW-1:0]  discard_cnt;

  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] target;
  logic        has_room;
  logic        req_fire;
  logic        rsp_fill;
  logic        rsp_drop;
  logic        head_valid;
  logic        deq;

  assign redirect      = jump_d | (pc_sel_e != 2'd0);
  assign raw_target    = (pc_sel_e == 2'd1) ? pc_imm_e :
                         (pc_sel_e[1]       ? alsu_res_e : pc_imm_d);
  assign target        = raw_target & ~32'd1;
  assign misaligned_pc = redirect & target[1];

  // Requests still in flight to be dropped count against capacity too
  assign has_room = ({1'b0, count} + {1'b0, discard_cnt}) < (CW+1)'(Depth);

  assign mem.i_req_valid = ~reset & ~halted & ~redirect & has_room;
  assign mem.i_req_addr  = fetch_pc;
  assign req_fire        = mem.i_req_valid & mem.i_req_ready;

  assign rsp_drop = mem.i_rsp_valid & (discard_cnt != '0);
  assign rsp_fill = mem.i_rsp_valid & (discard_cnt == '0);

  assign head_valid = (count != '0) & filled_q[head];
  assign deq        = head_valid & (~stall | flush);

  assign valid_f = head_valid;
  assign instr_f = head_valid ? data_q[head] : NopInstr;
  assign pc_f    = (count != '0) ? pc_q[head] : fetch_pc;
  assign pc4_f   = pc_f + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= BootVector;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      count       <= '0;
      pending     <= '0;
      discard_cnt <= '0;
      filled_q    <= '0;
    end else if (redirect) begin
      // A same-cycle response retires one pending entry or one discard, never both
      fetch_pc    <= target;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      count       <= '0;
      pending     <= '0;
      filled_q    <= '0;
      discard_cnt <= discard_cnt + pending - CW'(mem.i_rsp_valid);
    end else begin
      if (rsp_fill) begin
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + PW'(1);
      end
      if (rsp_drop)
        discard_cnt <= discard_cnt - CW'(1);
      if (deq) begin
        filled_q[head] <= 1'b0;
        head           <= head + PW'(1);
      end
      if (req_fire) begin
        tail     <= tail + PW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      count   <= count + CW'(req_fire) - CW'(deq);
      pending <= pending + CW'(req_fire) - CW'(rsp_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      pc_q[tail] <= fetch_pc;
    if (rsp_fill)
      data_q[fill_ptr] <= mem.i_rsp_data;
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_squash_cnt <= '0;
      perf_bubble_cnt <= '0;
    end else begin
      if (rsp_drop && !(&perf_squash_cnt))
        perf_squash_cnt <= perf_squash_cnt + 32'd1;
      if (!head_valid && !halted && !stall && !(&perf_bubble_cnt))
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
